// File: rtl/gold_code_gen_if.sv
// Bus bundle for gold_code_gen: code control inputs and code/status outputs.
// The master side drives control, the slave side (the generator) drives status.
// When GOLD_CODE_GEN_EPOCH_CNT_EN is defined, the bundle also carries
// epoch_cnt and bit_edge.
interface gold_code_gen_if #(
    parameter int N  = 10,
    parameter int PW = 11
);
    logic          rd;
    logic          mode;
    logic [3:0]    T0;
    logic [3:0]    T1;
    logic [N-1:0]  g2_init;
    logic          load;
    logic          slew_req;
    logic [PW-1:0] slew_chips;
    logic          slew_busy;
    logic          chip;
    logic [N-1:0]  g1;
    logic [PW-1:0] phase;
    logic          epoch;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
    logic [4:0]    epoch_cnt;
    logic          bit_edge;
`endif

    modport master (
        output rd, mode, T0, T1, g2_init, load, slew_req, slew_chips,
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
        input  epoch_cnt, bit_edge,
`endif
        input  slew_busy, chip, g1, phase, epoch
    );

    modport slave (
        input  rd, mode, T0, T1, g2_init, load, slew_req, slew_chips,
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
        output epoch_cnt, bit_edge,
`endif
        output slew_busy, chip, g1, phase, epoch
    );
endinterface

// File: rtl/gold_code_gen.sv
// Gold code generator: two N-stage Fibonacci LFSRs (G1, G2) combined into a
// chip stream, with phase tracking, period-wrap epoch pulse and a slew hold
// that absorbs a programmed number of rd strobes.
// Optional feature macro: GOLD_CODE_GEN_EPOCH_CNT_EN adds epoch_cnt (mod-20
// epoch counter) and bit_edge (pulse when that counter wraps to 0).
module gold_code_gen #(
    parameter int            N        = 10,
    parameter logic [N-1:0]  G1_TAPS  = 10'b1000000100,
    parameter logic [N-1:0]  G2_TAPS  = 10'b1110100110,
    parameter int            CODE_LEN = 1023,
    parameter int            PW       = 11
) (
    input  logic           clk,
    input  logic           rst,
    gold_code_gen_if.slave bus
);
    localparam logic [0:0]    S_IDLE     = 1'b0;
    localparam logic [0:0]    S_SLEW     = 1'b1;
    localparam logic [N-1:0]  ALL_ONES   = {N{1'b1}};
    localparam logic [PW-1:0] LAST_PHASE = PW'(CODE_LEN - 1);

    logic [0:0]    state_q,  state_d;
    logic [PW-1:0] hold_q,   hold_d;
    logic [N-1:0]  g1_q,     g1_d;
    logic [N-1:0]  g2_q,     g2_d;
    logic [PW-1:0] phase_q,  phase_d;
    logic          epoch_q,  epoch_d;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
    logic [4:0]    epoch_cnt_q, epoch_cnt_d;
    logic          bit_edge_q,  bit_edge_d;
`endif

    // Bit k-1 of a register holds stage k; shifting moves stage k to k+1.
    logic          g1_fb;
    logic          g2_fb;
    logic [N-1:0]  g2_restart;
    logic [N-1:0]  t0_mask;
    logic [N-1:0]  t1_mask;
    logic          g2_t0;
    logic          g2_t1;

    assign g1_fb      = ^(g1_q & G1_TAPS);
    assign g2_fb      = ^(g2_q & G2_TAPS);
    assign g2_restart = bus.mode ? bus.g2_init : ALL_ONES;

    // Out-of-range tap indices select nothing rather than an undefined bit.
    assign t0_mask = {{(N-1){1'b0}}, 1'b1} << (bus.T0 - 4'd1);
    assign t1_mask = {{(N-1){1'b0}}, 1'b1} << (bus.T1 - 4'd1);
    assign g2_t0   = |(g2_q & t0_mask);
    assign g2_t1   = |(g2_q & t1_mask);

    assign bus.chip      = bus.mode ? (g1_q[N-1] ^ g2_q[N-1])
                                    : (g1_q[N-1] ^ g2_t0 ^ g2_t1);
    assign bus.g1        = g1_q;
    assign bus.phase     = phase_q;
    assign bus.epoch     = epoch_q;
    assign bus.slew_busy = (state_q == S_SLEW);
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
    assign bus.epoch_cnt = epoch_cnt_q;
    assign bus.bit_edge  = bit_edge_q;
`endif

    // Next-state: load restarts everything; in IDLE rd advances the code
    // (wrapping at the period end); in SLEW rd only counts down the hold.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        g1_d    = g1_q;
        g2_d    = g2_q;
        phase_d = phase_q;
        epoch_d = 1'b0;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
        epoch_cnt_d = epoch_cnt_q;
        bit_edge_d  = 1'b0;
`endif
        if (bus.load) begin
            g1_d    = ALL_ONES;
            g2_d    = g2_restart;
            phase_d = '0;
            state_d = S_IDLE;
            hold_d  = '0;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
            epoch_cnt_d = '0;
`endif
        end else if (state_q == S_IDLE) begin
            // A slew request arms the hold; a same-cycle rd still advances.
            if (bus.slew_req && (bus.slew_chips != '0)) begin
                state_d = S_SLEW;
                hold_d  = bus.slew_chips;
            end
            if (bus.rd) begin
                if (phase_q == LAST_PHASE) begin
                    g1_d    = ALL_ONES;
                    g2_d    = g2_restart;
                    phase_d = '0;
                    epoch_d = 1'b1;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
                    if (epoch_cnt_q == 5'd19) begin
                        epoch_cnt_d = '0;
                        bit_edge_d  = 1'b1;
                    end else begin
                        epoch_cnt_d = epoch_cnt_q + 5'd1;
                    end
`endif
                end else begin
                    g1_d    = {g1_q[N-2:0], g1_fb};
                    g2_d    = {g2_q[N-2:0], g2_fb};
                    phase_d = phase_q + PW'(1);
                end
            end
        end else if (bus.rd) begin
            hold_d = hold_q - PW'(1);
            if (hold_q == PW'(1)) begin
                state_d = S_IDLE;
            end
        end
    end

    // State registers with asynchronous active-low reset to the code start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            g1_q    <= ALL_ONES;
            g2_q    <= ALL_ONES;
            phase_q <= '0;
            epoch_q <= 1'b0;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
            epoch_cnt_q <= '0;
            bit_edge_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            g1_q    <= g1_d;
            g2_q    <= g2_d;
            phase_q <= phase_d;
            epoch_q <= epoch_d;
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
            epoch_cnt_q <= epoch_cnt_d;
            bit_edge_q  <= bit_edge_d;
`endif
        end
    end
endmodule

// File: tb/tb_gold_code_gen.sv
// Self-checking bench for gold_code_gen: reference model built from
// precomputed LFSR state tables indexed by chip phase, directed scenarios
// with literal expectations, then randomized traffic.
module tb_gold_code_gen;
    localparam int N   = 10;
    localparam int PW  = 11;
    localparam int LEN = 1023;
    localparam logic [N-1:0] G1T = 10'b1000000100;
    localparam logic [N-1:0] G2T = 10'b1110100110;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gold_code_gen_if #(.N(N), .PW(PW)) bus ();

    gold_code_gen #(
        .N(N), .G1_TAPS(G1T), .G2_TAPS(G2T), .CODE_LEN(LEN), .PW(PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // State of each register after p shifts from its origin
    logic [N-1:0] g1_tab  [LEN];
    logic [N-1:0] g2o_tab [LEN];
    logic [N-1:0] g2i_tab [LEN];
    logic [N-1:0] g2_init_v;

    // Model: phase, which G2 origin applies, remaining slew strobes, epoch
    int m_p    = 0;
    bit m_org  = 1'b0;
    int m_slew = 0;
    bit m_ep   = 1'b0;
    int m_ecnt = 0;
    bit m_bedge = 1'b0;

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s, input logic [N-1:0] taps);
        logic [N-1:0] r;
        logic fb;
        fb = 1'b0;
        for (int k = 1; k <= N; k++) if (taps[k-1]) fb = fb ^ s[k-1];
        r = '0;
        r[0] = fb;
        for (int k = 2; k <= N; k++) r[k-1] = s[k-2];
        return r;
    endfunction

    task automatic build_tables();
        logic [N-1:0] a, b, c;
        a = '1; b = '1; c = g2_init_v;
        for (int p = 0; p < LEN; p++) begin
            g1_tab[p] = a; g2o_tab[p] = b; g2i_tab[p] = c;
            a = lfsr_step(a, G1T); b = lfsr_step(b, G2T); c = lfsr_step(c, G2T);
        end
    endtask

    function automatic logic model_chip();
        logic [N-1:0] a, b;
        a = g1_tab[m_p];
        b = m_org ? g2i_tab[m_p] : g2o_tab[m_p];
        if (bus.mode) return a[N-1] ^ b[N-1];
        return a[N-1] ^ b[int'(bus.T0) - 1] ^ b[int'(bus.T1) - 1];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model update from the spec's rules
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_p <= 0; m_org <= 1'b0; m_slew <= 0; m_ep <= 1'b0; m_ecnt <= 0; m_bedge <= 1'b0;
        end else if (bus.load) begin
            m_p <= 0; m_org <= bus.mode; m_slew <= 0; m_ep <= 1'b0; m_ecnt <= 0; m_bedge <= 1'b0;
        end else begin
            m_ep <= 1'b0;
            m_bedge <= 1'b0;
            if (m_slew == 0) begin
                if (bus.slew_req && bus.slew_chips != '0) m_slew <= int'(bus.slew_chips);
                if (bus.rd) begin
                    if (m_p == LEN - 1) begin
                        m_p <= 0; m_org <= bus.mode; m_ep <= 1'b1;
                        if (m_ecnt == 19) begin m_ecnt <= 0; m_bedge <= 1'b1; end
                        else m_ecnt <= m_ecnt + 1;
                    end else begin
                        m_p <= m_p + 1;
                    end
                end
            end else if (bus.rd) begin
                m_slew <= m_slew - 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        chk("phase", 32'(bus.phase), 32'(m_p));
        chk("g1", 32'(bus.g1), 32'(g1_tab[m_p]));
        chk("chip", 32'(bus.chip), 32'(model_chip()));
        chk("epoch", 32'(bus.epoch), 32'(m_ep));
        chk("slew_busy", 32'(bus.slew_busy), 32'(m_slew != 0));
`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
        chk("epoch_cnt", 32'(bus.epoch_cnt), 32'(m_ecnt));
        chk("bit_edge", 32'(bus.bit_edge), 32'(m_bedge));
`endif
    end

    // One clock: drive at negedge+1, return at the next negedge
    task automatic cyc(input logic r, input logic ld, input logic sr, input int sc);
        #1;
        bus.rd = r; bus.load = ld; bus.slew_req = sr; bus.slew_chips = PW'(sc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b0;
        bus.rd = 1'b0; bus.load = 1'b0; bus.slew_req = 1'b0; bus.slew_chips = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] prn1;
        logic [N-1:0] gs;
        prn1 = 10'b1100100000;
        bus.rd = 1'b0; bus.mode = 1'b0; bus.T0 = 4'd2; bus.T1 = 4'd6;
        bus.load = 1'b0; bus.slew_req = 1'b0; bus.slew_chips = '0;
        // G2 initial state whose stage-N output reproduces the PRN 1 G2 stream
        g2_init_v = '1;
        build_tables();
        for (int t = 0; t < N; t++) begin
            gs = g2o_tab[t];
            g2_init_v[N-1-t] = gs[1] ^ gs[5];
        end
        build_tables();
        bus.g2_init = g2_init_v;

        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_g1", 32'(bus.g1), 32'h3FF);
        chk("rst_epoch", 32'(bus.epoch), 32'd0);
        chk("rst_busy", 32'(bus.slew_busy), 32'd0);

        // PRN 1 first ten chips in mode 0
        for (int k = 0; k < 10; k++) begin
            chk("prn1_chip_m0", 32'(bus.chip), 32'(prn1[9-k]));
            cyc(1'b1, 1'b0, 1'b0, 0);
        end

        // Full period: no epoch after 1022 strobes, epoch after 1023rd
        do_reset();
        for (int i = 0; i < LEN - 1; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        chk("pre_wrap_epoch", 32'(bus.epoch), 32'd0);
        chk("pre_wrap_phase", 32'(bus.phase), 32'd1022);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("wrap_epoch", 32'(bus.epoch), 32'd1);
        chk("wrap_phase", 32'(bus.phase), 32'd0);
        chk("wrap_g1", 32'(bus.g1), 32'h3FF);
        cyc(1'b0, 1'b0, 1'b0, 0);
        chk("post_wrap_epoch", 32'(bus.epoch), 32'd0);

        // Slew of 5 at phase 100, then 8 strobes
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 5);
        chk("slew_start_busy", 32'(bus.slew_busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 0);
            chk("slew_busy_seq", 32'(bus.slew_busy), 32'(i < 5));
            chk("slew_phase_seq", 32'(bus.phase), 32'((i <= 5) ? 100 : 95 + i));
        end
        chk("slew_end_phase", 32'(bus.phase), 32'd103);

        // Zero-length slew request is ignored
        cyc(1'b0, 1'b0, 1'b1, 0);
        chk("slew_zero_busy", 32'(bus.slew_busy), 32'd0);

        // Reset in the middle of a slew
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 5);
        cyc(1'b1, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 0);
        #1;
        bus.rd = 1'b0;
        rst = 1'b0;
        #1;
        chk("midslew_rst_busy", 32'(bus.slew_busy), 32'd0);
        chk("midslew_rst_phase", 32'(bus.phase), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 0);
        chk("after_rst_phase", 32'(bus.phase), 32'd1);

        // Mode 1 with the PRN 1 G2 initial state
        #1 bus.mode = 1'b1;
        @(negedge clk);
        cyc(1'b0, 1'b1, 1'b0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("prn1_chip_m1", 32'(bus.chip), 32'(prn1[9-k]));
            cyc(1'b1, 1'b0, 1'b0, 0);
        end
        cyc(1'b1, 1'b1, 1'b0, 0);
        chk("load_rd_phase", 32'(bus.phase), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            #1;
            rst           = ($urandom_range(0, 1999) != 0);
            bus.rd        = ($urandom_range(0, 9) < 7);
            bus.load      = ($urandom_range(0, 799) == 0);
            bus.slew_req  = ($urandom_range(0, 29) == 0);
            bus.slew_chips = PW'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 49) == 0) begin
                bus.T0 = 4'($urandom_range(1, N));
                bus.T1 = 4'($urandom_range(1, N));
            end
            @(negedge clk);
        end
        #1 rst = 1'b1;
        bus.mode = 1'b0; bus.T0 = 4'd2; bus.T1 = 4'd6;
        @(negedge clk);

`ifdef GOLD_CODE_GEN_EPOCH_CNT_EN
        // Twenty periods: counter steps and bit_edge on the 20th epoch
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            for (int i = 0; i < LEN; i++) cyc(1'b1, 1'b0, 1'b0, 0);
            chk("ecnt_epoch", 32'(bus.epoch), 32'd1);
            chk("ecnt_value", 32'(bus.epoch_cnt), 32'(e % 20));
            chk("ecnt_bit_edge", 32'(bus.bit_edge), 32'(e == 20));
        end
        cyc(1'b0, 1'b0, 1'b0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
